// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS-subset control FSM (Moore): FETCH/DECODE/EXEC/MEM/WB/HALT with PC and IR.
// Define MIPS_MC_CONTROL_PERF_EN to add the cycle_cnt/instr_cnt performance counters.
module mips_mc_control #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] instr,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        alu_zero,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic        rf_we,
    output logic        rf_dst_rt,
    output logic        mem_to_reg,
    output logic        alu_src_imm,
    output logic [2:0]  state,
`ifdef MIPS_MC_CONTROL_PERF_EN
    output logic        halt,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`else
    output logic        halt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;

    logic [5:0] opcode;
    logic       is_rtype, is_addi, is_lw, is_sw, is_beq, is_j, is_legal;

    assign opcode   = ir_q[31:26];
    assign is_rtype = (opcode == OP_RTYPE);
    assign is_addi  = (opcode == OP_ADDI);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_j     = (opcode == OP_J);
    assign is_legal = is_rtype | is_addi | is_lw | is_sw | is_beq | is_j;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = instr;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_j) begin
                    pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                    state_d = S_FETCH;
                end else if (!is_legal) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_beq) begin
                    // pc already holds the fall-through address, so the offset is PC+4 relative
                    if (alu_zero) begin
                        pc_d = pc_q + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
                    end
                    state_d = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    state_d = is_sw ? S_FETCH : S_WB;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        rf_we       = 1'b0;
        rf_dst_rt   = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_imm = 1'b0;
        halt        = 1'b0;
        case (state_q)
            S_FETCH: imem_req = 1'b1;
            S_EXEC: begin
                alu_src_imm = is_addi | is_lw | is_sw;
            end
            S_MEM: begin
                dmem_req    = 1'b1;
                dmem_we     = is_sw;
                alu_src_imm = is_addi | is_lw | is_sw;
            end
            S_WB: begin
                rf_we       = 1'b1;
                rf_dst_rt   = is_lw | is_addi;
                mem_to_reg  = is_lw;
                alu_src_imm = is_addi | is_lw | is_sw;
            end
            S_HALT:  halt = 1'b1;
            default: ;
        endcase
    end

    assign pc    = pc_q;
    assign ir    = ir_q;
    assign state = state_q;

`ifdef MIPS_MC_CONTROL_PERF_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instr_cnt_q, instr_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (state_q != S_HALT) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
        // an instruction retires whenever the FSM returns to FETCH from a later state
        if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_HALT) begin
            instr_cnt_d = instr_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule
